// File: rtl/reset_sequencer.sv
// reset_sequencer: clock-manager supervisor and staggered multi-domain reset sequencer.
//
// Runs on the free-running board clock. Holds the DCM/PLL in reset, waits for lock, then
// releases CHANNELS active-high resets one at a time (bit 0 first). Lock loss, CLKFX stop
// or a debounced button press restarts the clock manager.
//
// Ports:
//   clk               free-running board clock (only clock)
//   reset_n           synchronous active-low block reset
//   btn_n             asynchronous push-button, active low
//   dcm_locked        asynchronous lock status
//   dcm_clkfx_stopped asynchronous CLKFX-stopped status
//   dcm_rst           clock-manager reset, active high
//   rst_out           per-domain resets, active high
//   ready             all channels released
//   fault_count       saturating count of lock losses in RELEASE/RUN
//   retry_count       saturating count of lock timeouts (0 unless watchdog build)
//
// Build option: define RESET_SEQ_WATCHDOG_EN to enable the WAIT_LOCK timeout and retry.
module reset_sequencer #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DCM_RST_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT    = 65536,
  parameter int unsigned RELEASE_DELAY   = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_n,
  input  logic                dcm_locked,
  input  logic                dcm_clkfx_stopped,
  output logic                dcm_rst,
  output logic [CHANNELS-1:0] rst_out,
  output logic                ready,
  output logic [7:0]          fault_count,
  output logic [7:0]          retry_count
);

  localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned MaxDr  = (DCM_RST_CYCLES > RELEASE_DELAY) ? DCM_RST_CYCLES
                                                                    : RELEASE_DELAY;
  localparam int unsigned CntMax = (MaxDr > LOCK_TIMEOUT) ? MaxDr : LOCK_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned ChW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [DebW-1:0] DebMax  = DebW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] DrLast  = CntW'(DCM_RST_CYCLES - 1);
  localparam logic [CntW-1:0] RelLast = CntW'(RELEASE_DELAY - 1);
  localparam logic [ChW-1:0]  ChLast  = ChW'(CHANNELS - 1);

  typedef enum logic [1:0] {StDcmRst, StWaitLock, StRelease, StRun} state_e;

  logic [SYNC_STAGES-1:0] btn_sync_q, lock_sync_q, stop_sync_q;
  logic                   btn_s, lock_s, stop_s;
  logic [DebW-1:0]        deb_q, deb_d;
  logic                   press;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ChW-1:0]      ch_q, ch_d;
  logic [CHANNELS-1:0] rst_q, rst_d;
  logic                dcm_rst_q, dcm_rst_d;
  logic                ready_q, ready_d;
  logic [7:0]          fault_q, fault_d;
  logic                fault, restart;

  // Input synchronizers and debounce counter; idle values match a released button and
  // an unlocked, running clock manager.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_sync_q  <= '1;
      lock_sync_q <= '0;
      stop_sync_q <= '0;
      deb_q       <= '0;
    end else begin
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_n};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], dcm_locked};
      stop_sync_q <= {stop_sync_q[SYNC_STAGES-2:0], dcm_clkfx_stopped};
      deb_q       <= deb_d;
    end
  end

  assign btn_s  = btn_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign stop_s = stop_sync_q[SYNC_STAGES-1];

  always_comb begin
    deb_d = deb_q;
    if (btn_s) begin
      deb_d = '0;
    end else if (deb_q != DebMax) begin
      deb_d = deb_q + DebW'(1);
    end
  end

  assign press = (deb_q == DebMax);

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam logic [CntW-1:0] ToLast = CntW'(LOCK_TIMEOUT - 1);
  logic [7:0] retry_q, retry_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    fault_d = fault_q;
    restart = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
    retry_d = retry_q;
`endif
    fault = ((state_q == StRelease) || (state_q == StRun)) && (!lock_s || stop_s);

    unique case (state_q)
      StDcmRst: begin
        // A held button keeps the restart window open until it is released.
        if (press) begin
          cnt_d = '0;
        end else if (cnt_q == DrLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitLock: begin
        if (press || stop_s) begin
          restart = 1'b1;
        end else if (lock_s) begin
          state_d = StRelease;
          cnt_d   = '0;
          ch_d    = '0;
        end
`ifdef RESET_SEQ_WATCHDOG_EN
        else if (cnt_q == ToLast) begin
          restart = 1'b1;
          if (retry_q != 8'hff) retry_d = retry_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StRelease: begin
        if (fault || press) begin
          restart = 1'b1;
        end else if (cnt_q == RelLast) begin
          cnt_d        = '0;
          rst_d[ch_q]  = 1'b0;
          if (ch_q == ChLast) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else begin
            ch_d = ch_q + ChW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (fault || press) restart = 1'b1;
      end
      default: restart = 1'b1;
    endcase

    // Fault and press together still count exactly one fault.
    if (fault && (fault_q != 8'hff)) fault_d = fault_q + 8'd1;

    if (restart) begin
      state_d = StDcmRst;
      cnt_d   = '0;
      ch_d    = '0;
      rst_d   = '1;
      ready_d = 1'b0;
    end
  end

  assign dcm_rst_d = (state_d == StDcmRst);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StDcmRst;
      cnt_q     <= '0;
      ch_q      <= '0;
      rst_q     <= '1;
      dcm_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      rst_q     <= rst_d;
      dcm_rst_q <= dcm_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

`ifdef RESET_SEQ_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
  assign retry_count = retry_q;
`else
  assign retry_count = 8'd0;
`endif

  assign dcm_rst     = dcm_rst_q;
  assign rst_out     = rst_q;
  assign ready       = ready_q;
  assign fault_count = fault_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised clock-manager supervisor and multi-domain reset sequencer for the FPGA top level. It runs on the free-running board clock and drives the DCM/PLL reset. It watches lock and CLKFX-stopped status, debounces the push-button reset and restarts the clock manager on lock loss or lock timeout. Once lock is obtained, it releases CHANNELS active-high reset outputs one at a time, staggered, so downstream `sync_reset` instances in the core clock domains come up in a fixed order.

## Interface
Parameters:
- CHANNELS, 4: number of sequenced reset outputs (1..16)
- SYNC_STAGES, 2: synchronizer flops on each asynchronous status input (≥2)
- DEBOUNCE_CYCLES, 1000000: consecutive low samples before a button press is accepted
- DCM_RST_CYCLES, 16: cycles `dcm_rst` is held high per restart
- LOCK_TIMEOUT, 65536: WAIT_LOCK cycles before retry (watchdog build only)
- RELEASE_DELAY, 256: cycles between successive channel releases

Ports:
- clk  in  1  free-running board clock; the only clock
- reset_n  in  1  synchronous, active-low block reset
- btn_n  in  1  asynchronous push-button, active low
- dcm_locked  in  1  asynchronous clock-manager lock status
- dcm_clkfx_stopped  in  1  asynchronous CLKFX-stopped status
- dcm_rst  out  1  clock-manager reset, active high
- rst_out  out  CHANNELS  per-domain resets, active high; bit 0 released first
- ready  out  1  high when all channels are released
- fault_count  out  8  saturating count of lock losses while running
- retry_count  out  8  saturating count of lock timeouts; constant 0 without the macro

## Operation
- Input conditioning:
  - Each asynchronous input passes through SYNC_STAGES flops, giving `btn_s`, `lock_s` and `stop_s`.
  - `btn_s` feeds a debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
  - `btn_s` low increments the counter; high clears it.
  - `press` is asserted while the counter equals DEBOUNCE_CYCLES, where it saturates.
- State machine, states DCM_RST, WAIT_LOCK, RELEASE, RUN, sharing one counter `cnt`:
  - **DCM_RST:**
    - `dcm_rst` = 1 and all `rst_out` = 1.
    - `cnt` counts to DCM_RST_CYCLES-1, then the FSM goes to WAIT_LOCK with `cnt` = 0.
    - While `press` is asserted, `cnt` is held at 0.
  - **WAIT_LOCK:**
    - `dcm_rst` = 0.
    - `lock_s` goes to RELEASE.
    - `stop_s` goes to DCM_RST, uncounted.
    - Watchdog build: `cnt` reaching LOCK_TIMEOUT-1 without lock goes to DCM_RST and increments `retry_count`.
  - **RELEASE:**
    - Channel index `ch` starts at 0.
    - Each time `cnt` reaches RELEASE_DELAY-1, the FSM clears `rst_out[ch]`, increments `ch` and clears `cnt`.
    - Releasing channel CHANNELS-1 goes to RUN.
  - **RUN:** `ready` = 1 and the FSM holds.
- Fault and button handling:
  - A fault is `!lock_s` or `stop_s` in RELEASE or RUN.
  - A fault goes to DCM_RST, sets all `rst_out` and `ready` back to their reset state, and increments `fault_count`.
  - `press` in any state goes to DCM_RST and does not count as a fault.
  - Fault and `press` in the same cycle: go to DCM_RST and increment `fault_count` once.
- Counters saturate at 255 and are cleared only by `reset_n`.

## Timing
- All outputs are registered.
- `reset_n` low is sampled on the clk edge. State after that edge:
  - FSM in DCM_RST with `cnt` = 0 and `ch` = 0
  - `dcm_rst` = 1, `rst_out` = all ones, `ready` = 0
  - `fault_count` = 0 and `retry_count` = 0
  - synchronizers and the debounce counter cleared to their idle values (`btn_s` = 1, `lock_s` = 0, `stop_s` = 0)
- Reset mid-sequence aborts immediately with the same values.
- `dcm_rst` stays high for exactly DCM_RST_CYCLES cycles after the first cycle `reset_n` is high; it falls on the cycle WAIT_LOCK is entered.
- Input-to-response latency is SYNC_STAGES+1 cycles. This applies to:
  - `dcm_locked` rising to entry into RELEASE
  - lock loss to `rst_out` all ones and `dcm_rst` high
- `rst_out[i]` falls (i+1)·RELEASE_DELAY cycles after RELEASE is entered.
- `ready` rises in the same cycle `rst_out[CHANNELS-1]` falls.
- A button press is recognised SYNC_STAGES+DEBOUNCE_CYCLES cycles after `btn_n` falls and stays low.
- A glitch shorter than DEBOUNCE_CYCLES is ignored.
- No output toggles more than once per cycle. A channel, once released, never re-asserts except through DCM_RST.

## Configuration
- `RESET_SEQ_WATCHDOG_EN` defined:
  - The WAIT_LOCK timeout and retry are active.
  - `retry_count` counts timeouts.
- `RESET_SEQ_WATCHDOG_EN` undefined:
  - WAIT_LOCK waits indefinitely; only `stop_s` or `press` leaves it without lock.
  - `retry_count` is tied to 0.
  - The LOCK_TIMEOUT parameter is ignored.

## Test plan
Bench settings: CHANNELS=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=10, DCM_RST_CYCLES=4, LOCK_TIMEOUT=16, RELEASE_DELAY=8.

1. Release `reset_n` with `dcm_locked` high from the start -> `dcm_rst` high for 4 cycles; `rst_out` bits fall in order 0, 1, 2 at 8, 16 and 24 cycles after RELEASE entry; `ready` = 1 with bit 2; both counters = 0.
2. Drop `dcm_locked` for 1 cycle while in RUN -> 3 cycles later `rst_out` = 3'b111, `ready` = 0, `dcm_rst` = 1 for 4 cycles, `fault_count` = 1; the full sequence then repeats.
3. Watchdog build with `dcm_locked` held low -> `dcm_rst` pulses of 4 cycles every 20 cycles; `retry_count` increments per pulse and saturates at 255 after 255 timeouts. Non-watchdog build -> a single pulse, then WAIT_LOCK is held forever and `retry_count` = 0.
4. `btn_n` low for 9 cycles, then low for 12 cycles, while in RUN -> the 9-cycle pulse causes no change; the 12-cycle pulse forces DCM_RST 12 cycles after the fall, holds `dcm_rst` while pressed plus 4 cycles after release, and leaves `fault_count` unchanged.
5. Lock loss in the same cycle `press` is recognised -> a single DCM_RST entry and `fault_count` incremented by exactly 1.
6. Assert `reset_n` low during RELEASE after bit 0 is released -> on the next edge `rst_out` = 3'b111, `dcm_rst` = 1 and both counters = 0.
